// File: rtl/mgmt_sram_arbiter.sv
// ---------------------------------------------------------------------------
// mgmt_sram_arbiter
//
// Multi-bank SRAM front end between the mgmt_core memory port and NBANKS
// DFFRAM banks, plus a read-only housekeeping port on the same clock.
// Requests to different banks are served in the same cycle. A same-bank
// conflict goes to the core unless the read-only port has already lost
// STARVE_LIMIT conflicts in a row, in which case the read-only port wins.
//
// Optional feature macro: MGMT_SRAM_STATS_EN
//   When defined, adds stat_clear / stat_conflicts (saturating count of
//   conflict cycles, whichever side won).
//
// Parameters
//   NBANKS        number of banks (2, 4 or 8)
//   BANK_AW       word-address width of one bank
//   STARVE_LIMIT  lost conflicts tolerated before the RO port wins (0..7,
//                 0 = RO port always wins a conflict)
//
// Ports
//   core_clk, core_rstn         clock, asynchronous active-low reset
//   mem_ena/wen/addr/wdata      core request (wen = 0 means read)
//   mem_ready                   core request accepted this cycle
//   mem_rdata                   core read data, cycle after acceptance
//   ro_req/ro_addr              housekeeping read request
//   ro_gnt                      RO request accepted this cycle
//   ro_valid/ro_data            RO read data, cycle after ro_gnt
//   bank_en/we/addr/wdata       flattened per-bank drive, bank b at slice b
//   bank_rdata                  flattened per-bank registered Do
//   stat_clear, stat_conflicts  (MGMT_SRAM_STATS_EN only)
// ---------------------------------------------------------------------------
module mgmt_sram_arbiter #(
  parameter  int NBANKS       = 2,
  parameter  int BANK_AW      = 8,
  parameter  int STARVE_LIMIT = 4,
  localparam int BW           = $clog2(NBANKS),
  localparam int AW           = BANK_AW + BW
) (
  input  logic                      core_clk,
  input  logic                      core_rstn,

  input  logic                      mem_ena,
  input  logic [3:0]                mem_wen,
  input  logic [AW-1:0]             mem_addr,
  input  logic [31:0]               mem_wdata,
  output logic                      mem_ready,
  output logic [31:0]               mem_rdata,

  input  logic                      ro_req,
  input  logic [AW-1:0]             ro_addr,
  output logic                      ro_gnt,
  output logic                      ro_valid,
  output logic [31:0]               ro_data,

`ifdef MGMT_SRAM_STATS_EN
  input  logic                      stat_clear,
  output logic [15:0]               stat_conflicts,
`endif

  output logic [NBANKS-1:0]         bank_en,
  output logic [4*NBANKS-1:0]       bank_we,
  output logic [BANK_AW*NBANKS-1:0] bank_addr,
  output logic [32*NBANKS-1:0]      bank_wdata,
  input  logic [32*NBANKS-1:0]      bank_rdata
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [BW-1:0] cb;
  logic [BW-1:0] rb;
  logic [BW-1:0] cb_q;
  logic [BW-1:0] rb_q;
  logic [2:0]    starve_cnt;
  logic          conflict;
  logic          ro_win;
  logic          core_gnt;

  assign cb = mem_addr[AW-1:BANK_AW];
  assign rb = ro_addr[AW-1:BANK_AW];

  // Grants are combinational in the request cycle. Every term is qualified
  // with core_rstn so that while reset is held no bank is enabled, ro_gnt
  // is low and mem_ready reads 1, whatever the requesters are doing.
  assign conflict  = core_rstn & mem_ena & ro_req & (cb == rb);
  assign ro_win    = conflict & (starve_cnt >= LIMIT);
  assign core_gnt  = core_rstn & mem_ena & ~ro_win;
  assign mem_ready = ~ro_win;
  assign ro_gnt    = core_rstn & ro_req & (~conflict | ro_win);

  // Bank drive. Core and RO grants never target the same bank in one cycle,
  // so the priority order below only matters for readability. Idle banks
  // are driven with zero and the RO port can never write.
  always_comb begin
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (core_gnt && (cb == BW'(b))) begin
        bank_en[b]                       = 1'b1;
        bank_we[b*4 +: 4]                = mem_wen;
        bank_addr[b*BANK_AW +: BANK_AW]  = mem_addr[BANK_AW-1:0];
        bank_wdata[b*32 +: 32]           = mem_wdata;
      end else if (ro_gnt && (rb == BW'(b))) begin
        bank_en[b]                       = 1'b1;
        bank_addr[b*BANK_AW +: BANK_AW]  = ro_addr[BANK_AW-1:0];
      end
    end
  end

  // Per-requester state: which bank to return data from next cycle, the
  // RO data-valid pulse, and the starvation counter. The counter only
  // grows while the RO port is waiting behind the core; any RO grant or a
  // withdrawn request restarts it. The async reset drops ro_valid, so a
  // grant taken just before reset never produces a data pulse.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      cb_q       <= '0;
      rb_q       <= '0;
      ro_valid   <= 1'b0;
      starve_cnt <= 3'd0;
    end else begin
      ro_valid <= ro_gnt;
      if (core_gnt) begin
        cb_q <= cb;
      end
      if (ro_gnt) begin
        rb_q <= rb;
      end
      if (!ro_req || ro_gnt) begin
        starve_cnt <= 3'd0;
      end else if (conflict && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

  // The banks register Do themselves, so the read-data muxes only need the
  // bank index captured at grant time.
  assign mem_rdata = bank_rdata[int'(cb_q)*32 +: 32];
  assign ro_data   = bank_rdata[int'(rb_q)*32 +: 32];

`ifdef MGMT_SRAM_STATS_EN
  // Conflict statistics: counts every conflict cycle regardless of winner,
  // sticks at all-ones, and a clear request beats a same-cycle increment.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      stat_conflicts <= 16'd0;
    end else if (stat_clear) begin
      stat_conflicts <= 16'd0;
    end else if (conflict && (stat_conflicts != 16'hFFFF)) begin
      stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`else
  // Statistics disabled: no counter and no extra ports in this build.
`endif

endmodule
